modulo_counter_prog: RTL and testbench
======================================

// Module: modulo_counter_prog
// PURPOSE
//  Parametrised, runtime-programmable modulo counter with clock-divide toggle output.
//  Counts 0..M-1 up or down, with enable and synchronous load.
//  Flags each wrap with a one-cycle terminal-count pulse and toggles `out` on every wrap.
//  Used as a general tick/divider source: out period = 2*M enabled cycles.
// PARAMETERS
//  WIDTH        8   counter, load and modulus width in bits (>=2)
//  RESET_VAL    0   value of state after reset (must be < any modulus used)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  en         in   1      count enable; state holds when low
//  up         in   1      direction: 1 = increment, 0 = decrement
//  load       in   1      synchronous load of load_val (priority over en)
//  load_val   in   WIDTH  value loaded when load=1
//  mod_val    in   WIDTH  modulus M, sampled every cycle; 0 means M = 2^WIDTH
//  state      out  WIDTH  current count (registered)
//  tc         out  1      one-cycle pulse; high in the cycle state shows a wrapped value
//  out        out  1      toggles on every wrap (divided clock)
//  range_err  out  1      one-cycle pulse: out-of-range count was corrected
// BEHAVIOUR
//  - One clock, sync active-high reset. All outputs registered; nothing combinational to outputs.
//  - Reset: state=RESET_VAL, out=0, tc=0, range_err=0. Reset overrides load/en.
//    Reset asserted mid-count takes effect at that edge and discards any pending wrap.
//  - Priority per edge: reset > load > en > hold.
//  - load=1: state<=load_val; tc=0; range_err=0; out unchanged.
//    load_val is not range-checked at load time.
//  - en=1, up=1, state==M-1: state<=0, tc<=1, out<=~out.
//  - en=1, up=0, state==0: state<=M-1, tc<=1, out<=~out.
//  - en=1 otherwise in range: state<=state+1 (up) or state-1 (down), tc<=0.
//  - Out of range (state>=M, possible after load or mod_val change) with en=1:
//    state<=0 (up) or M-1 (down); range_err<=1; tc<=0; out unchanged.
//    This correction is not counted as a wrap.
//  - en=0 and load=0: state, out hold; tc<=0, range_err<=0.
//  - M=1: state stays 0; every enabled cycle is a wrap (tc=1 continuously, out toggles each cycle).
//  - M=0 (2^WIDTH): natural binary wrap, 2^WIDTH-1 <-> 0; range_err never fires.
//  - Arithmetic in WIDTH bits; M-1 computed as mod_val-1 mod 2^WIDTH (0 -> all ones).
//  - mod_val change takes effect on the next edge; no reset of state or out.
//  - Latency: input sampled at edge N is visible on state/tc/out after edge N.
// TESTING
//  1. reset, mod_val=6, up=1, en=1 for 12 cycles -> state 0,1..5,0,1..5,0;
//     tc high with state=0 at cycles 6,12; out 0->1->0.
//  2. mod_val=6, up=0 from reset -> state 5,4..0,5; tc with each 5; out toggles at first step.
//  3. load=1, load_val=9, mod_val=6, then en=1 up=1 -> state 9 then 0, range_err=1, tc=0, out unchanged.
//  4. en toggled 1,0,0,1 with mod_val=3 -> state holds while en=0, tc never during hold.
//  5. WIDTH=8, mod_val=0, up=1, from load_val=255 -> state 0, tc=1, range_err=0;
//     mod_val=1 -> tc stays high, out toggles every cycle.
//  6. reset asserted while state=M-1 and en=1 -> state=RESET_VAL, tc=0, out=0 next cycle; no wrap.

Source files
------------

// File: rtl/modulo_counter_prog.sv
// Runtime-programmable modulo-M up/down counter with terminal-count pulse,
// divide-by-2M toggle output and out-of-range correction flag.
module modulo_counter_prog #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] state,
    output logic             tc,
    output logic             out,
    output logic             range_err
);

    logic [WIDTH-1:0] m_last;
    logic             in_range;
    logic             at_top;
    logic             at_bottom;

    logic [WIDTH-1:0] state_next;
    logic             tc_next;
    logic             out_next;
    logic             range_err_next;

    // mod_val == 0 encodes M = 2^WIDTH, so M-1 wraps naturally to all ones
    // and every representable count is in range.
    assign m_last    = mod_val - WIDTH'(1);
    assign in_range  = (mod_val == '0) || (state < mod_val);
    assign at_top    = (state == m_last);
    assign at_bottom = (state == '0);

    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; a missing default here would infer a latch.
    always_comb begin
        state_next     = state;
        tc_next        = 1'b0;
        out_next       = out;
        range_err_next = 1'b0;

        if (load) begin
            state_next = load_val;
        end else if (en) begin
            if (!in_range) begin
                // Correction back into range is deliberately not a wrap.
                state_next     = up ? '0 : m_last;
                range_err_next = 1'b1;
            end else if (up) begin
                if (at_top) begin
                    state_next = '0;
                    tc_next    = 1'b1;
                    out_next   = ~out;
                end else begin
                    state_next = state + WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
                    state_next = m_last;
                    tc_next    = 1'b1;
                    out_next   = ~out;
                end else begin
                    state_next = state - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: registered state uses non-blocking assignments so all flops update
    // together from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RESET_VAL;
            tc        <= 1'b0;
            out       <= 1'b0;
            range_err <= 1'b0;
        end else begin
            state     <= state_next;
            tc        <= tc_next;
            out       <= out_next;
            range_err <= range_err_next;
        end
    end

endmodule

// File: tb/tb_modulo_counter_prog.sv
// Directed self-checking bench for modulo_counter_prog (WIDTH=8, RESET_VAL=0).
module tb_modulo_counter_prog;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] state;
    logic             tc;
    logic             out;
    logic             range_err;

    int n_checks = 0;
    int n_fail   = 0;

    modulo_counter_prog #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .mod_val   (mod_val),
        .state     (state),
        .tc        (tc),
        .out       (out),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] s, input logic t,
                             input logic o, input logic r);
        check({tag, ".state"}, 32'(state), 32'(s));
        check({tag, ".tc"}, 32'(tc), 32'(t));
        check({tag, ".out"}, 32'(out), 32'(o));
        check({tag, ".range_err"}, 32'(range_err), 32'(r));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [7:0] down_state [7] = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd5};
    logic       down_tc    [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       down_out   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    logic       hold_en    [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] hold_state [5] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd0};
    logic       hold_tc    [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b1;
        load_val = 8'd77; mod_val = 8'd6;
        #1;
        step();
        reset = 1'b0; load = 1'b0;
        check_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);

        // Up-count modulo 6: wraps at cycles 6 and 12.
        en = 1'b1; up = 1'b1; mod_val = 8'd6;
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("up6[%0d].state", i), 32'(state), 32'(i % 6));
            check($sformatf("up6[%0d].tc", i), 32'(tc), 32'(i % 6 == 0));
            check($sformatf("up6[%0d].out", i), 32'(out), 32'(i >= 6 && i < 12));
        end

        // Down-count modulo 6 from reset: immediate wrap to 5.
        do_reset();
        up = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check_all($sformatf("down6[%0d]", i), down_state[i], down_tc[i], down_out[i], 1'b0);
        end

        // Load out of range, then corrective step up and down.
        en = 1'b0; load = 1'b1; load_val = 8'd9; mod_val = 8'd6;
        step();
        check_all("load9", 8'd9, 1'b0, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check_all("fix_up", 8'd0, 1'b0, 1'b0, 1'b1);
        step();
        check_all("after_fix", 8'd1, 1'b0, 1'b0, 1'b0);
        load = 1'b1; load_val = 8'd200;
        step();
        check_all("load200_en", 8'd200, 1'b0, 1'b0, 1'b0);
        load = 1'b0; up = 1'b0;
        step();
        check_all("fix_down", 8'd5, 1'b0, 1'b0, 1'b1);
        // Load has priority over a concurrent enable.
        load = 1'b1; load_val = 8'd2;
        step();
        check_all("load_prio", 8'd2, 1'b0, 1'b0, 1'b0);
        load = 1'b0;

        // Enable gating, modulus 3.
        do_reset();
        mod_val = 8'd3; up = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en = hold_en[i];
            step();
            check($sformatf("hold[%0d].state", i), 32'(state), 32'(hold_state[i]));
            check($sformatf("hold[%0d].tc", i), 32'(tc), 32'(hold_tc[i]));
        end
        check("hold.out", 32'(out), 32'd1);
        en = 1'b0;
        step();
        check_all("hold_after_wrap", 8'd0, 1'b0, 1'b1, 1'b0);

        // M = 2^WIDTH: natural binary wrap both ways.
        mod_val = 8'd0; load = 1'b1; load_val = 8'd255;
        step();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step();
        check_all("m0_up_wrap", 8'd0, 1'b1, 1'b0, 1'b0);
        up = 1'b0;
        step();
        check_all("m0_down_wrap", 8'd255, 1'b1, 1'b1, 1'b0);
        step();
        check_all("m0_down", 8'd254, 1'b0, 1'b1, 1'b0);

        // M = 1: continuous wrap; first edge corrects 254 down to 0.
        mod_val = 8'd1; up = 1'b1;
        step();
        check_all("m1_fix", 8'd0, 1'b0, 1'b1, 1'b1);
        step();
        check_all("m1_a", 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("m1_b", 8'd0, 1'b1, 1'b1, 1'b0);
        up = 1'b0;
        step();
        check_all("m1_down", 8'd0, 1'b1, 1'b0, 1'b0);

        // Reset at M-1 with enable high discards the pending wrap.
        do_reset();
        mod_val = 8'd4; up = 1'b1; en = 1'b1;
        repeat (3) step();
        check_all("pre_reset", 8'd3, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        check_all("reset_at_top", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        check_all("post_reset", 8'd1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
